// File: rtl/fifo_drain.sv
// Read-side adapter for a block-RAM FIFO: pops words, absorbs the one-cycle
// read latency in a 2-entry skid buffer and presents a registered valid/ready stream.
module fifo_drain #(
  parameter int DATA_ = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             fifo_empty_,
  output logic             fifo_re,
  input  logic [DATA_-1:0] fifo_dout,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DATA_-1:0] m_data,
  output logic [1:0]       level
);

  logic [1:0]       occ_r;
  logic             inflight_r;
  logic             valid_r;
  logic [DATA_-1:0] head_r;
  logic [DATA_-1:0] tail_r;

  logic             pop_s;
  logic [2:0]       sum_s;
  logic [1:0]       occ_after_pop_s;

  // Handshake, projected occupancy and the pop request toward the FIFO.
  always_comb begin
    pop_s           = valid_r & m_ready;
    sum_s           = {1'b0, occ_r} + {2'b00, inflight_r} - {2'b00, pop_s};
    occ_after_pop_s = occ_r - {1'b0, pop_s};
    if (fifo_empty_ && !flush && !rst && (sum_s < 3'd2)) begin
      fifo_re = 1'b1;
    end else begin
      fifo_re = 1'b0;
    end
  end

  // Skid buffer state: occupancy, in-flight tracking, head/tail data.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_r      <= 2'd0;
      inflight_r <= 1'b0;
      valid_r    <= 1'b0;
      head_r     <= {DATA_{1'b0}};
      tail_r     <= {DATA_{1'b0}};
    end else if (flush) begin
      // A word landing on fifo_dout this cycle is dropped along with the buffer.
      occ_r      <= 2'd0;
      inflight_r <= 1'b0;
      valid_r    <= 1'b0;
    end else begin
      occ_r      <= sum_s[1:0];
      inflight_r <= fifo_re;
      valid_r    <= (sum_s != 3'd0);
      if (pop_s && (occ_r == 2'd2)) begin
        head_r <= tail_r;
      end
      if (inflight_r) begin
        case (occ_after_pop_s)
          2'd0:    head_r <= fifo_dout;
          2'd1:    tail_r <= fifo_dout;
          default: tail_r <= tail_r;
        endcase
      end
    end
  end

  assign m_valid = valid_r;
  assign m_data  = head_r;
  assign level   = occ_r;

endmodule

// File: tb/tb_fifo_drain.sv
// Bench for fifo_drain: directed cycle table, hand-written corner sequences and
// random traffic checked against a queue-based model of the adapter.
module tb_fifo_drain;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       fifo_empty_;
  logic       fifo_re;
  logic [7:0] fifo_dout;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic [1:0] level;

  fifo_drain #(.DATA_(8)) dut (
    .clk(clk), .rst(rst), .flush(flush), .fifo_empty_(fifo_empty_),
    .fifo_re(fifo_re), .fifo_dout(fifo_dout), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .level(level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int re_cnt = 0;
  int pop_cnt = 0;

  logic [7:0] fifo_q[$];   // words still inside the upstream FIFO
  logic [7:0] adq[$];      // words popped from the FIFO and owned by the adapter
  logic       inflight_m = 1'b0;

  typedef struct packed {
    logic       rdy;
    logic       fl;
    logic       rs;
    logic       e_re;
    logic       e_v;
    logic [1:0] e_lvl;
    logic       cd;
    logic [7:0] e_data;
  } vec_t;

  vec_t tbl[22];

  logic       o_re, o_v;
  logic [1:0] o_lvl;
  logic [7:0] o_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare against the model, advance the model.
  task automatic step(input logic rdy, input logic fl, input logic rs, input logic gap);
    int sz, occ_m;
    logic pop_m, exp_v, exp_re, re_d;
    logic [7:0] w;
    m_ready     = rdy;
    flush       = fl;
    rst         = rs;
    fifo_empty_ = (fifo_q.size() != 0) && !gap;
    #1;
    sz     = adq.size();
    occ_m  = sz - (inflight_m ? 1 : 0);
    exp_v  = (occ_m != 0);
    pop_m  = exp_v && rdy;
    exp_re = fifo_empty_ && !fl && !rs && ((sz - (pop_m ? 1 : 0)) < 2);
    chk("fifo_re", 32'(fifo_re), 32'(exp_re));
    chk("m_valid", 32'(m_valid), 32'(exp_v));
    chk("level", 32'(level), 32'(occ_m));
    if (exp_v) chk("m_data", 32'(m_data), 32'(adq[0]));
    if (inflight_m) chk("capture_slot_free", 32'((occ_m - (pop_m ? 1 : 0)) <= 1), 32'd1);
    o_re = fifo_re; o_v = m_valid; o_lvl = level; o_data = m_data;
    re_d = fifo_re;
    if (re_d) re_cnt++;
    if (pop_m) pop_cnt++;
    @(posedge clk);
    w = fifo_dout;
    if (re_d && fifo_q.size() != 0) w = fifo_q.pop_front();
    if (rs || fl) begin
      adq.delete();
      inflight_m = 1'b0;
    end else begin
      if (pop_m && adq.size() != 0) void'(adq.pop_front());
      if (re_d) adq.push_back(w);
      inflight_m = re_d;
    end
    #1;
    fifo_dout = w;
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] nextv;
    rst = 1'b1; flush = 1'b0; fifo_empty_ = 1'b0; m_ready = 1'b0; fifo_dout = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_fifo_re", 32'(fifo_re), 32'd0);
    chk("reset_m_valid", 32'(m_valid), 32'd0);
    chk("reset_m_data", 32'(m_data), 32'd0);
    chk("reset_level", 32'(level), 32'd0);

    // Directed table: stream, stall, flush at occ=2, reset mid-stream.
    tbl[0]  = '{1'b1,1'b0,1'b0, 1'b1,1'b0,2'd0,1'b1,8'h00};
    tbl[1]  = '{1'b1,1'b0,1'b0, 1'b1,1'b0,2'd0,1'b1,8'h00};
    tbl[2]  = '{1'b1,1'b0,1'b0, 1'b1,1'b1,2'd1,1'b1,8'h01};
    tbl[3]  = '{1'b1,1'b0,1'b0, 1'b1,1'b1,2'd1,1'b1,8'h02};
    tbl[4]  = '{1'b1,1'b0,1'b0, 1'b1,1'b1,2'd1,1'b1,8'h03};
    tbl[5]  = '{1'b0,1'b0,1'b0, 1'b0,1'b1,2'd1,1'b1,8'h04};
    tbl[6]  = '{1'b0,1'b0,1'b0, 1'b0,1'b1,2'd2,1'b1,8'h04};
    tbl[7]  = '{1'b0,1'b0,1'b0, 1'b0,1'b1,2'd2,1'b1,8'h04};
    tbl[8]  = '{1'b1,1'b0,1'b0, 1'b1,1'b1,2'd2,1'b1,8'h04};
    tbl[9]  = '{1'b1,1'b0,1'b0, 1'b1,1'b1,2'd1,1'b1,8'h05};
    tbl[10] = '{1'b1,1'b0,1'b0, 1'b1,1'b1,2'd1,1'b1,8'h06};
    tbl[11] = '{1'b0,1'b0,1'b0, 1'b0,1'b1,2'd1,1'b1,8'h07};
    tbl[12] = '{1'b0,1'b1,1'b0, 1'b0,1'b1,2'd2,1'b1,8'h07};
    tbl[13] = '{1'b1,1'b0,1'b0, 1'b1,1'b0,2'd0,1'b0,8'h00};
    tbl[14] = '{1'b1,1'b0,1'b0, 1'b1,1'b0,2'd0,1'b0,8'h00};
    tbl[15] = '{1'b1,1'b0,1'b0, 1'b1,1'b1,2'd1,1'b1,8'h09};
    tbl[16] = '{1'b1,1'b0,1'b0, 1'b1,1'b1,2'd1,1'b1,8'h0A};
    tbl[17] = '{1'b0,1'b0,1'b1, 1'b0,1'b1,2'd1,1'b1,8'h0B};
    tbl[18] = '{1'b1,1'b0,1'b1, 1'b0,1'b0,2'd0,1'b1,8'h00};
    tbl[19] = '{1'b1,1'b0,1'b0, 1'b1,1'b0,2'd0,1'b1,8'h00};
    tbl[20] = '{1'b1,1'b0,1'b0, 1'b1,1'b0,2'd0,1'b1,8'h00};
    tbl[21] = '{1'b1,1'b0,1'b0, 1'b1,1'b1,2'd1,1'b1,8'h0D};

    for (int i = 1; i <= 16; i++) fifo_q.push_back(8'(i));
    for (int i = 0; i < 22; i++) begin
      step(tbl[i].rdy, tbl[i].fl, tbl[i].rs, 1'b0);
      chk($sformatf("tbl%0d_re", i), 32'(o_re), 32'(tbl[i].e_re));
      chk($sformatf("tbl%0d_valid", i), 32'(o_v), 32'(tbl[i].e_v));
      chk($sformatf("tbl%0d_level", i), 32'(o_lvl), 32'(tbl[i].e_lvl));
      if (tbl[i].cd) chk($sformatf("tbl%0d_data", i), 32'(o_data), 32'(tbl[i].e_data));
    end

    // Single word: fifo_empty_ high for exactly one cycle.
    fifo_q.delete();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    re_cnt = 0; pop_cnt = 0;
    fifo_q.push_back(8'hA5);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("single_re_pulses", 32'(re_cnt), 32'd1);
    chk("single_words", 32'(pop_cnt), 32'd1);
    chk("single_level_end", 32'(level), 32'd0);

    // Toggling m_ready, then fully random traffic with gaps, flushes and resets.
    nextv = 8'h20;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 1) == 0) begin fifo_q.push_back(nextv); nextv++; end
      step(1'(i % 2 == 0), 1'b0, 1'b0, 1'($urandom_range(0, 3) == 0));
    end
    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(0, 1) == 0) begin fifo_q.push_back(nextv); nextv++; end
      step(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 39) == 0),
           1'($urandom_range(0, 149) == 0), 1'($urandom_range(0, 3) == 0));
    end
    for (int i = 0; i < 60; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("drain_fifo_empty", 32'(fifo_q.size()), 32'd0);
    chk("drain_level", 32'(level), 32'd0);
    chk("drain_valid", 32'(m_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
